// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the SPI transmit arbiter.
package spi_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    DONE
  } state_t;

  localparam logic [3:0] HDR_MAGIC = 4'hA;
  localparam int         LEN_W     = 8;
  localparam int         WORD_W    = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requester above last_grant, else lowest overall.
module rr_arbiter #(
  parameter  int REQUESTERS = 4,
  localparam int IDX_W      = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]      last_grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  any
);

  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             hi_any;

  // Descending scan so the last hit recorded is the lowest index in each half.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    any    = 1'b0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = IDX_W'(i);
        any    = 1'b1;
        if (IDX_W'(i) > last_grant) begin
          hi_idx = IDX_W'(i);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign grant_idx = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/spi_tx_arbiter.sv
// Round-robin, message-locked arbiter sharing one SPI transmit port.
// Define SPI_TX_HEADER_EN to prefix each message with {HDR_MAGIC, grant_id, req_len}.
module spi_tx_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int WORD_W     = 16,
  parameter int MAX_WORDS  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [REQUESTERS-1:0]        req_valid,
  input  logic [REQUESTERS-1:0]        req_last,
  input  logic [REQUESTERS*WORD_W-1:0] req_data,
  input  logic [REQUESTERS*8-1:0]      req_len,
  output logic [REQUESTERS-1:0]        req_ready,
  output logic [15:0]                  spi_out,
  output logic                         write,
  input  logic                         spi_tx_ready,
  output logic                         busy,
  output logic [3:0]                   grant_id,
  output logic                         msg_done,
  output logic                         overrun
);
  import spi_tx_pkg::*;

  localparam int IDX_W = $clog2(REQUESTERS);
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

  state_t            state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [IDX_W-1:0]  g;
  logic              xfer;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit_max;
  logic [WORD_W-1:0] lane_data [REQUESTERS];

  assign g       = grant_id[IDX_W-1:0];
  assign xfer    = (state == DATA) && req_valid[g] && spi_tx_ready && !write;
  assign cnt_inc = word_cnt + 1'b1;
  assign busy    = (state != IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < REQUESTERS; gi++) begin : g_lane
      assign lane_data[gi] = req_data[gi*WORD_W +: WORD_W];
      assign req_ready[gi] = xfer && (g == IDX_W'(gi));
    end
  endgenerate

`ifdef SPI_TX_HEADER_EN
  logic [LEN_W-1:0] lane_len [REQUESTERS];
  generate
    for (gi = 0; gi < REQUESTERS; gi++) begin : g_len
      assign lane_len[gi] = req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate
`else
  logic unused_len;
  assign unused_len = ^req_len;
`endif

  rr_arbiter #(.REQUESTERS(REQUESTERS)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(REQUESTERS - 1);
      grant_id   <= '0;
      word_cnt   <= '0;
      hit_max    <= 1'b0;
      spi_out    <= '0;
      write      <= 1'b0;
      msg_done   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      write    <= 1'b0;
      msg_done <= 1'b0;
      overrun  <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_id <= 4'(arb_idx);
            word_cnt <= '0;
            hit_max  <= 1'b0;
`ifdef SPI_TX_HEADER_EN
            state    <= HEADER;
`else
            state    <= DATA;
`endif
          end
        end
`ifdef SPI_TX_HEADER_EN
        HEADER: begin
          if (spi_tx_ready && !write) begin
            spi_out <= {HDR_MAGIC, grant_id, lane_len[g]};
            write   <= 1'b1;
            state   <= DATA;
          end
        end
`endif
        DATA: begin
          if (xfer) begin
            spi_out <= lane_data[g];
            write   <= 1'b1;
            if (word_cnt != CNT_MAX) word_cnt <= cnt_inc;
            // An explicit last word wins over the length guard.
            if (req_last[g]) begin
              state <= DONE;
            end else if (cnt_inc == CNT_MAX) begin
              state   <= DONE;
              hit_max <= 1'b1;
            end
          end
        end
        DONE: begin
          msg_done   <= 1'b1;
          overrun    <= hit_max;
          last_grant <= g;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter (REQUESTERS=4, MAX_WORDS=4); follows SPI_TX_HEADER_EN.
`timescale 1ns/1ps
module tb_spi_tx_arbiter;
  localparam int R    = 4;
  localparam int MAXW = 4;
`ifdef SPI_TX_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [R-1:0]  req_valid, req_last, req_ready;
  logic [R*16-1:0] req_data;
  logic [R*8-1:0]  req_len;
  logic [15:0]   spi_out;
  logic          write, spi_tx_ready, busy, msg_done, overrun;
  logic [3:0]    grant_id;

  always #5 clk = ~clk;

  spi_tx_arbiter #(.REQUESTERS(R), .WORD_W(16), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_len(req_len), .req_ready(req_ready),
    .spi_out(spi_out), .write(write), .spi_tx_ready(spi_tx_ready),
    .busy(busy), .grant_id(grant_id), .msg_done(msg_done), .overrun(overrun)
  );

  typedef struct {logic [15:0] data; logic last; logic [7:0] len;} word_t;
  typedef struct {int gid; logic ov;} done_t;
  typedef struct packed {logic [3:0] mask; logic [3:0] reps; logic [3:0] n; logic [31:0] order;} arb_vec_t;

  word_t       src_q [R][$];
  logic [15:0] exp_q [$];
  done_t       done_q [$];
  logic [R-1:0] hold = '0;
  logic [R-1:0] ready_mask = '0;
  int errors = 0, checks = 0, cyc_n = 0, last_wr = -1, n_wr = 0;
  bit exact_gap = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    req_valid = '0; req_last = '0; req_data = '0; req_len = '0;
    for (int i = 0; i < R; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        req_valid[i]         = 1'b1;
        req_last[i]          = src_q[i][0].last;
        req_data[i*16 +: 16] = src_q[i][0].data;
        req_len[i*8 +: 8]    = src_q[i][0].len;
      end
    end
  endtask

  task automatic src_push(int i, int n, logic [15:0] base, logic [15:0] step, bit with_last);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.data = base + 16'(k) * step;
      w.last = with_last && (k == n - 1);
      w.len  = 8'(n);
      src_q[i].push_back(w);
    end
  endtask

  task automatic exp_push(int i, int n, logic [15:0] base, logic [15:0] step, bit with_last);
    done_t d;
    if (HDR != 0) exp_q.push_back({4'hA, 4'(i), 8'(n)});
    for (int k = 0; k < n; k++) exp_q.push_back(base + 16'(k) * step);
    d.gid = i;
    d.ov  = !with_last && (n >= MAXW);
    done_q.push_back(d);
  endtask

  // Negedge monitor: scoreboard pop on every strobe, grant/overrun check on every msg_done.
  task automatic mon();
    done_t d;
    logic [15:0] e;
    logic [R-1:0] oh;
    cyc_n++;
    ready_mask = req_ready;
    if (req_ready != '0 && done_q.size() > 0) begin
      oh = '0;
      oh[done_q[0].gid] = 1'b1;
      check("ready_grantee_only", req_ready, oh);
    end
    if (write) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got spi_out=%h, required no write", spi_out);
      end else begin
        e = exp_q.pop_front();
        $display("tx %0d t=%0t spi_out=%h grant=%0d", n_wr, $time, spi_out, grant_id);
        check("spi_out", spi_out, e);
      end
      if (last_wr >= 0) begin
        if (exact_gap) check("write_gap", cyc_n - last_wr, 2);
        else           check("write_gap_min", (cyc_n - last_wr >= 2), 1);
      end
      last_wr = cyc_n;
    end
    if (msg_done) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_msg_done: got grant_id=%0d, required none", grant_id);
      end else begin
        d = done_q.pop_front();
        check("done_grant_id", grant_id, d.gid);
        check("done_overrun", overrun, d.ov);
        check("done_latency", cyc_n - last_wr, 1);
      end
      last_wr = -1;
    end else if (overrun) begin
      check("overrun_without_done", overrun, 0);
    end
  endtask

  task automatic post();
    @(posedge clk); #1;
    for (int i = 0; i < R; i++)
      if (ready_mask[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    post();
  endtask

  task automatic wait_idle(string name, int budget);
    int k = 0;
    int left;
    while ((exp_q.size() > 0 || done_q.size() > 0 || busy) && k < budget) begin
      cyc();
      k++;
    end
    left = exp_q.size() + done_q.size();
    for (int i = 0; i < R; i++) left += src_q[i].size();
    check({name, "_drained"}, left, 0);
  endtask

  task automatic run_to_writes(string name, int target, int budget);
    int k = 0;
    while (n_wr < target && k < budget) begin
      cyc();
      k++;
    end
    check({name, "_reached"}, (n_wr >= target), 1);
  endtask

  arb_vec_t tbl [5];

  initial begin
    int rep_cnt [R];
    int lane, n0;
    bit hit;

    spi_tx_ready = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_spi_out", spi_out, 0);
    check("rst_write", write, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_msg_done", msg_done, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    spi_tx_ready = 1'b1;

    // Basic 3-word message from requester 0 at full rate.
    exact_gap = 1'b1;
    src_push(0, 3, 16'h1111, 16'h1111, 1'b1);
    exp_push(0, 3, 16'h1111, 16'h1111, 1'b1);
    drive();
    wait_idle("single_msg", 60);
    exact_gap = 1'b0;

    // Round-robin table: lanes loaded in ascending order, expected grant order listed.
    tbl[0] = '{mask: 4'b1010, reps: 4'd1, n: 4'd2, order: 32'h0000_0031};
    tbl[1] = '{mask: 4'b1111, reps: 4'd1, n: 4'd4, order: 32'h0000_3210};
    tbl[2] = '{mask: 4'b0110, reps: 4'd1, n: 4'd2, order: 32'h0000_0021};
    tbl[3] = '{mask: 4'b1001, reps: 4'd1, n: 4'd2, order: 32'h0000_0003};
    tbl[4] = '{mask: 4'b0101, reps: 4'd2, n: 4'd4, order: 32'h0000_0202};
    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < int'(tbl[r].reps); p++)
        for (int i = 0; i < R; i++)
          if (tbl[r].mask[i]) src_push(i, 1, {4'hC, 4'(r), 4'(i), 4'(p)}, 16'h0, 1'b1);
      for (int i = 0; i < R; i++) rep_cnt[i] = 0;
      for (int k = 0; k < int'(tbl[r].n); k++) begin
        lane = int'(tbl[r].order[4*k +: 4]);
        exp_push(lane, 1, {4'hC, 4'(r), 4'(lane), 4'(rep_cnt[lane])}, 16'h0, 1'b1);
        rep_cnt[lane]++;
      end
      drive();
      wait_idle("rr_row", 200);
    end

    // Shifter stalls 5 cycles mid-message (requester 1 wins after last_grant=0).
    src_push(1, 3, 16'h4001, 16'h1, 1'b1);
    exp_push(1, 3, 16'h4001, 16'h1, 1'b1);
    drive();
    n0 = n_wr;
    run_to_writes("stall_pre", n0 + HDR + 1, 40);
    spi_tx_ready = 1'b0;
    drive();
    repeat (5) begin
      @(negedge clk);
      check("stall_write", write, 0);
      check("stall_req_ready", req_ready, 0);
      mon();
      post();
    end
    spi_tx_ready = 1'b1;
    wait_idle("stall", 60);

    // Grantee 2 drops valid for 10 cycles while requester 3 waits.
    src_push(2, 2, 16'h5001, 16'h1, 1'b1);
    src_push(3, 1, 16'h6001, 16'h1, 1'b1);
    exp_push(2, 2, 16'h5001, 16'h1, 1'b1);
    exp_push(3, 1, 16'h6001, 16'h1, 1'b1);
    drive();
    n0 = n_wr;
    run_to_writes("lock_pre", n0 + HDR + 1, 40);
    hold[2] = 1'b1;
    drive();
    repeat (10) begin
      @(negedge clk);
      check("lock_req_ready3", req_ready[3], 0);
      check("lock_busy", busy, 1);
      check("lock_write", write, 0);
      mon();
      post();
    end
    hold = '0;
    drive();
    wait_idle("lock", 80);

    // Overrun at MAX_WORDS, then a normal message, then last-on-limit (no overrun).
    src_push(0, 4, 16'h7001, 16'h1, 1'b0);
    src_push(1, 1, 16'h7101, 16'h1, 1'b1);
    src_push(2, 4, 16'h7201, 16'h1, 1'b1);
    exp_push(0, 4, 16'h7001, 16'h1, 1'b0);
    exp_push(1, 1, 16'h7101, 16'h1, 1'b1);
    exp_push(2, 4, 16'h7201, 16'h1, 1'b1);
    drive();
    wait_idle("overrun", 120);

    // Reset asserted while the 2nd data word is on the port.
    src_push(1, 3, 16'h8001, 16'h1, 1'b1);
    exp_push(1, 3, 16'h8001, 16'h1, 1'b1);
    drive();
    n0  = n_wr;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      mon();
      if (n_wr >= n0 + HDR + 2) hit = 1'b1;
      else post();
    end
    check("midrst_reached", hit, 1);
    check("midrst_write_before", write, 1);
    #1 rst = 1'b0;
    #1;
    check("midrst_write", write, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_spi_out", spi_out, 0);
    check("midrst_msg_done", msg_done, 0);
    exp_q.delete();
    done_q.delete();
    for (int i = 0; i < R; i++) src_q[i].delete();
    last_wr = -1;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    src_push(1, 1, 16'h9101, 16'h1, 1'b1);
    src_push(0, 1, 16'h9001, 16'h1, 1'b1);
    exp_push(0, 1, 16'h9001, 16'h1, 1'b1);
    exp_push(1, 1, 16'h9101, 16'h1, 1'b1);
    drive();
    wait_idle("post_reset", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
